// File: rtl/alu_pkg.sv
// Shared opcode map, status bit positions and FSM state encoding for alu_seq.
// ALU_MUL_EN adds the MUL state to the state enum.
package alu_pkg;

   localparam logic [4:0] OP_INC = 5'b00001;
   localparam logic [4:0] OP_DEC = 5'b00011;
   localparam logic [4:0] OP_ADD = 5'b00100;
   localparam logic [4:0] OP_ADC = 5'b00101;
   localparam logic [4:0] OP_SUB = 5'b00110;
   localparam logic [4:0] OP_SBB = 5'b00111;
   localparam logic [4:0] OP_AND = 5'b01000;
   localparam logic [4:0] OP_OR  = 5'b01001;
   localparam logic [4:0] OP_XOR = 5'b01010;
   localparam logic [4:0] OP_NOT = 5'b01011;
   localparam logic [4:0] OP_SHL = 5'b10000;
   localparam logic [4:0] OP_SHR = 5'b10001;
   localparam logic [4:0] OP_SAL = 5'b10010;
   localparam logic [4:0] OP_SAR = 5'b10011;
   localparam logic [4:0] OP_ROL = 5'b10100;
   localparam logic [4:0] OP_ROR = 5'b10101;
   localparam logic [4:0] OP_RCL = 5'b10110;
   localparam logic [4:0] OP_RCR = 5'b10111;
   localparam logic [4:0] OP_MUL = 5'b11000;

   localparam int ST_C  = 0;
   localparam int ST_Z  = 1;
   localparam int ST_S  = 2;
   localparam int ST_P  = 3;
   localparam int ST_V  = 4;
   localparam int ST_AF = 5;

`ifdef ALU_MUL_EN
   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE, S_MUL} state_t;
`else
   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;
`endif

   function automatic logic is_shift_op(input logic [4:0] op);
      return op[4:3] == 2'b10;
   endfunction

   function automatic logic even_parity(input logic [7:0] v);
      return ~^v;
   endfunction

   function automatic logic [5:0] pack_status(input logic c, input logic z, input logic s,
                                              input logic p, input logic v, input logic af);
      logic [5:0] st;
      st = '0;
      st[ST_C]  = c;
      st[ST_Z]  = z;
      st[ST_S]  = s;
      st[ST_P]  = p;
      st[ST_V]  = v;
      st[ST_AF] = af;
      return st;
   endfunction

endpackage

// File: rtl/alu_seq_core.sv
// Combinational single-cycle datapath: arithmetic, logic and zero-count shifts.
// Unused opcodes (including MUL, which is iterated in alu_seq when ALU_MUL_EN is set) hold status.
module alu_seq_core
   import alu_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [4:0]       op,
   input  logic             carry_q,
   input  logic [5:0]       status_prev,
   output logic [WIDTH-1:0] result,
   output logic [5:0]       status
);

   logic [WIDTH-1:0] opnd;
   logic             cin;
   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   diff;
   logic             c, v, af, hold;

   always_comb begin
      opnd = (op == OP_INC || op == OP_DEC) ? WIDTH'(1) : b;
      cin  = (op == OP_ADC || op == OP_SBB) ? carry_q : 1'b0;
      sum  = {1'b0, a} + {1'b0, opnd} + {{WIDTH{1'b0}}, cin};
      diff = {1'b0, a} - {1'b0, opnd} - {{WIDTH{1'b0}}, cin};
   end

   // AF uses a[4]^b[4]^r[4]: the carry/borrow crossing from bit 3 into bit 4.
   always_comb begin
      result = '0;
      c      = 1'b0;
      v      = 1'b0;
      af     = 1'b0;
      hold   = 1'b0;
      case (op)
         OP_INC, OP_ADD, OP_ADC: begin
            result = sum[WIDTH-1:0];
            c      = (op == OP_INC) ? carry_q : sum[WIDTH];
            v      = (a[WIDTH-1] == opnd[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            af     = a[4] ^ opnd[4] ^ sum[4];
         end
         OP_DEC, OP_SUB, OP_SBB: begin
            result = diff[WIDTH-1:0];
            c      = (op == OP_DEC) ? carry_q : diff[WIDTH];
            v      = (a[WIDTH-1] != opnd[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            af     = a[4] ^ opnd[4] ^ diff[4];
         end
         OP_AND: result = a & b;
         OP_OR:  result = a | b;
         OP_XOR: result = a ^ b;
         OP_NOT: result = ~a;
         OP_SHL, OP_SHR, OP_SAL, OP_SAR, OP_ROL, OP_ROR, OP_RCL, OP_RCR: begin
            result = a;
            c      = carry_q;
         end
         default: hold = 1'b1;
      endcase
   end

   always_comb begin
      if (hold)
         status = status_prev;
      else
         status = pack_status(c, result == '0, result[WIDTH-1],
                              even_parity(result[7:0]), v, af);
   end

endmodule

// File: rtl/alu_seq.sv
// Handshaked sequential ALU: one operation in flight, bit-serial shifts/rotates.
// Define ALU_MUL_EN to build the iterative shift-add MUL (opcode 11000).
module alu_seq
   import alu_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [4:0]       op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic [5:0]       status
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW:0] CNT_ONE = (CW+1)'(1);

   state_t           state_reg;
   logic [WIDTH-1:0] result_reg;
   logic [5:0]       status_reg;
   logic             out_valid_reg;
   logic [4:0]       op_reg;
   logic [WIDTH-1:0] sh_reg;
   logic             cy_reg;
   logic             msb_reg;
   logic [CW:0]      cnt_reg;

   logic [WIDTH-1:0] core_result;
   logic [5:0]       core_status;
   logic [WIDTH-1:0] step_val;
   logic             step_cy;
   logic             carry_q;

   // The stored carry is exactly the C bit of the last completed operation.
   assign carry_q   = status_reg[ST_C];
   assign in_ready  = (state_reg == S_IDLE) && !rst;
   assign out_valid = out_valid_reg;
   assign result    = result_reg;
   assign status    = status_reg;

   alu_seq_core #(.WIDTH(WIDTH)) u_core (
      .a           (a),
      .b           (b),
      .op          (op),
      .carry_q     (carry_q),
      .status_prev (status_reg),
      .result      (core_result),
      .status      (core_status)
   );

   // One 1-bit step of the captured shift/rotate; RCL/RCR run through cy_reg.
   always_comb begin
      step_val = sh_reg;
      step_cy  = cy_reg;
      case (op_reg)
         OP_SHL, OP_SAL: begin
            step_cy  = sh_reg[WIDTH-1];
            step_val = {sh_reg[WIDTH-2:0], 1'b0};
         end
         OP_SHR: begin
            step_cy  = sh_reg[0];
            step_val = {1'b0, sh_reg[WIDTH-1:1]};
         end
         OP_SAR: begin
            step_cy  = sh_reg[0];
            step_val = {sh_reg[WIDTH-1], sh_reg[WIDTH-1:1]};
         end
         OP_ROL: begin
            step_cy  = sh_reg[WIDTH-1];
            step_val = {sh_reg[WIDTH-2:0], sh_reg[WIDTH-1]};
         end
         OP_ROR: begin
            step_cy  = sh_reg[0];
            step_val = {sh_reg[0], sh_reg[WIDTH-1:1]};
         end
         OP_RCL: begin
            step_cy  = sh_reg[WIDTH-1];
            step_val = {sh_reg[WIDTH-2:0], cy_reg};
         end
         OP_RCR: begin
            step_cy  = sh_reg[0];
            step_val = {cy_reg, sh_reg[WIDTH-1:1]};
         end
         default: ;
      endcase
   end

`ifdef ALU_MUL_EN
   logic [WIDTH-1:0]   mcand_reg;
   logic [2*WIDTH-1:0] prod_reg;
   logic [WIDTH:0]     mul_sum;
   logic [2*WIDTH-1:0] mul_next;

   // Multiplier sits in the low half of prod_reg and is consumed LSB first.
   always_comb begin
      mul_sum  = {1'b0, prod_reg[2*WIDTH-1:WIDTH]} + (prod_reg[0] ? {1'b0, mcand_reg} : '0);
      mul_next = {mul_sum, prod_reg[WIDTH-1:1]};
   end
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= S_IDLE;
         result_reg    <= '0;
         status_reg    <= '0;
         out_valid_reg <= 1'b0;
         op_reg        <= '0;
         sh_reg        <= '0;
         cy_reg        <= 1'b0;
         msb_reg       <= 1'b0;
         cnt_reg       <= '0;
`ifdef ALU_MUL_EN
         mcand_reg     <= '0;
         prod_reg      <= '0;
`endif
      end else begin
         case (state_reg)
            S_IDLE: begin
               if (in_valid) begin
                  op_reg  <= op;
                  sh_reg  <= a;
                  cy_reg  <= carry_q;
                  msb_reg <= a[WIDTH-1];
                  if (is_shift_op(op) && b[CW-1:0] != '0) begin
                     cnt_reg   <= {1'b0, b[CW-1:0]};
                     state_reg <= S_SHIFT;
                  end
`ifdef ALU_MUL_EN
                  else if (op == OP_MUL) begin
                     mcand_reg <= a;
                     prod_reg  <= {{WIDTH{1'b0}}, b};
                     cnt_reg   <= (CW+1)'(WIDTH);
                     state_reg <= S_MUL;
                  end
`endif
                  else begin
                     result_reg    <= core_result;
                     status_reg    <= core_status;
                     out_valid_reg <= 1'b1;
                     state_reg     <= S_DONE;
                  end
               end
            end
            S_SHIFT: begin
               sh_reg  <= step_val;
               cy_reg  <= step_cy;
               cnt_reg <= cnt_reg - CNT_ONE;
               if (cnt_reg == CNT_ONE) begin
                  result_reg    <= step_val;
                  status_reg    <= pack_status(step_cy, step_val == '0, step_val[WIDTH-1],
                                               even_parity(step_val[7:0]),
                                               step_val[WIDTH-1] ^ msb_reg, 1'b0);
                  out_valid_reg <= 1'b1;
                  state_reg     <= S_DONE;
               end
            end
`ifdef ALU_MUL_EN
            S_MUL: begin
               prod_reg <= mul_next;
               cnt_reg  <= cnt_reg - CNT_ONE;
               if (cnt_reg == CNT_ONE) begin
                  result_reg    <= mul_next[WIDTH-1:0];
                  status_reg    <= pack_status(mul_next[2*WIDTH-1:WIDTH] != '0,
                                               mul_next[WIDTH-1:0] == '0,
                                               mul_next[WIDTH-1],
                                               even_parity(mul_next[7:0]),
                                               mul_next[2*WIDTH-1:WIDTH] != '0, 1'b0);
                  out_valid_reg <= 1'b1;
                  state_reg     <= S_DONE;
               end
            end
`endif
            S_DONE: begin
               if (out_ready) begin
                  out_valid_reg <= 1'b0;
                  state_reg     <= S_IDLE;
               end
            end
            default: state_reg <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq (WIDTH=16); MUL expectations follow ALU_MUL_EN.
module tb_alu_seq;
   import alu_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] a;
   logic [15:0] b;
   logic [4:0]  op;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] result;
   logic [5:0]  status;

   int total = 0;
   int bad   = 0;
   int lat;
   int rdy_seen;
   int ov_seen;

   always #5 clk = ~clk;

   alu_seq #(.WIDTH(16)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .op        (op),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .status    (status)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Offer one op, wait for acceptance, then scramble inputs to prove capture.
   task automatic issue(input logic [4:0] o, input logic [15:0] av, input logic [15:0] bv);
      int guard;
      guard = 0;
      while (!in_ready && guard < 50) begin
         tick();
         guard++;
      end
      check("ready_before_issue", in_ready, 1);
      in_valid = 1'b1;
      op = o;
      a  = av;
      b  = bv;
      tick();
      in_valid = 1'b0;
      a  = 16'($urandom);
      b  = 16'($urandom);
      op = 5'($urandom);
   endtask

   // Latency counted as cycles after the acceptance edge until out_valid is seen.
   task automatic wait_out();
      lat = 1;
      rdy_seen = int'(in_ready);
      while (!out_valid && lat < 100) begin
         tick();
         lat++;
         rdy_seen = rdy_seen | int'(in_ready);
      end
   endtask

   task automatic run(input string tag, input logic [4:0] o, input logic [15:0] av,
                      input logic [15:0] bv, input logic [15:0] er, input logic [5:0] es,
                      input int el);
      issue(o, av, bv);
      wait_out();
      check({tag, "_lat"}, lat, el);
      check({tag, "_result"}, result, er);
      check({tag, "_status"}, status, es);
      check({tag, "_ready_low"}, rdy_seen, 0);
      tick();
      check({tag, "_transferred"}, out_valid, 0);
      $display("op %s: a=%h b=%h result=%h status=%h latency=%0d", tag, av, bv, result, status, lat);
   endtask

   initial begin
      rst = 1'b1;
      in_valid = 1'b0;
      out_ready = 1'b1;
      a = '0;
      b = '0;
      op = '0;
      tick();
      tick();
      check("rst_in_ready", in_ready, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_result", result, 16'h0000);
      check("rst_status", status, 6'h00);
      rst = 1'b0;
      #1;
      check("post_rst_in_ready", in_ready, 1);

      run("add", OP_ADD, 16'h7FFF, 16'h0001, 16'h8000, 6'h3C, 1);
      run("sub", OP_SUB, 16'hFFFE, 16'hFFFF, 16'hFFFF, 6'h2D, 1);
      run("sbb", OP_SBB, 16'h0007, 16'h0003, 16'h0003, 6'h08, 1);
      run("sub_setc", OP_SUB, 16'h0000, 16'h0001, 16'hFFFF, 6'h2D, 1);
      run("rcr3", OP_RCR, 16'h8F00, 16'h0003, 16'h31E0, 6'h10, 4);
      run("inc", OP_INC, 16'hFFFF, 16'h1234, 16'h0000, 6'h2A, 1);
      run("dec", OP_DEC, 16'h8000, 16'h0000, 16'h7FFF, 6'h38, 1);
      run("xor", OP_XOR, 16'hFF00, 16'h0F0F, 16'hF00F, 6'h0C, 1);
      run("not", OP_NOT, 16'h00FF, 16'hAAAA, 16'hFF00, 6'h0C, 1);
      run("shl1", OP_SHL, 16'h8001, 16'h0001, 16'h0002, 6'h11, 2);
      run("rol0", OP_ROL, 16'h1234, 16'h0010, 16'h1234, 6'h01, 1);
      run("sar4", OP_SAR, 16'h8000, 16'h0004, 16'hF800, 6'h0C, 5);
      run("unused", 5'b11111, 16'h1234, 16'h5678, 16'h0000, 6'h0C, 1);

      // Back-pressure: result held while a competing op is offered but refused.
      out_ready = 1'b0;
      issue(OP_AND, 16'h0007, 16'h0003);
      wait_out();
      check("and_lat", lat, 1);
      in_valid = 1'b1;
      op = OP_XOR;
      a  = 16'h0001;
      b  = 16'h0007;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("hold_valid", out_valid, 1);
         check("hold_result", result, 16'h0003);
         check("hold_status", status, 6'h08);
         check("hold_in_ready", in_ready, 0);
      end
      $display("op and_hold: result=%h status=%h held 5 cycles", result, status);
      out_ready = 1'b1;
      tick();
      check("hold_transfer_once", out_valid, 0);
      check("hold_ready_again", in_ready, 1);
      tick();
      in_valid = 1'b0;
      check("queued_xor_valid", out_valid, 1);
      check("queued_xor_result", result, 16'h0006);
      check("queued_xor_status", status, 6'h08);
      tick();
      $display("op queued_xor: result=%h status=%h", result, status);

      // Reset in the middle of a long rotate discards it.
      issue(OP_ROL, 16'hF0F0, 16'h000F);
      for (int i = 0; i < 4; i++) tick();
      rst = 1'b1;
      tick();
      check("midrst_out_valid", out_valid, 0);
      check("midrst_result", result, 16'h0000);
      check("midrst_status", status, 6'h00);
      check("midrst_in_ready", in_ready, 0);
      rst = 1'b0;
      #1;
      check("midrst_ready_after", in_ready, 1);
      ov_seen = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         ov_seen = ov_seen | int'(out_valid);
      end
      check("midrst_no_emit", ov_seen, 0);
      $display("op rol15_reset: discarded, result=%h status=%h", result, status);

      run("adc_after_rst", OP_ADC, 16'h000F, 16'h0001, 16'h0010, 6'h20, 1);
`ifdef ALU_MUL_EN
      run("mul", OP_MUL, 16'h0100, 16'h0100, 16'h0000, 6'h1B, 17);
`else
      run("mul_unused", OP_MUL, 16'h0100, 16'h0100, 16'h0000, 6'h20, 1);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, handshaked, sequential successor to the 16-bit combinational ALU. It keeps the 5-bit opcode map and the 6-bit status word. It adds a configurable datapath width and a valid/ready interface on input and output. It adds a carry flag register that ADC/SBB/RCL/RCR consume, and multi-bit shifts/rotates executed one bit per cycle. It sits between the instruction issue stage and writeback as a single-outstanding-operation execution unit.

## Interface
- WIDTH, 16: datapath width; must be ≥ 8.
- CW, $clog2(WIDTH): derived shift-count width; not overridden.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operation offered.
- in_ready  out  1  operation accepted when in_valid && in_ready.
- a, b  in  WIDTH  operands; b[CW-1:0] is the shift/rotate count.
- op  in  5  opcode.
- out_valid  out  1  result/status valid.
- out_ready  in  1  consumer accepts the result when out_valid && out_ready.
- result  out  WIDTH  registered result.
- status  out  6  registered flags: [0] C, [1] Z, [2] S, [3] P, [4] V, [5] AF.

## Operation
- Opcodes:
  - 00001 INC, 00011 DEC, 00100 ADD, 00101 ADC, 00110 SUB, 00111 SBB.
  - 01000 AND, 01001 OR, 01010 XOR, 01011 NOT (~a).
  - 10000 SHL, 10001 SHR, 10010 SAL, 10011 SAR, 10100 ROL, 10101 ROR, 10110 RCL, 10111 RCR.
  - All other codes are unused: result = 0, status = previous status, 1-cycle latency.
- Internal carry_q holds the C bit of the last completed operation. ADC = a+b+carry_q; SBB = a-b-carry_q; RCL/RCR rotate through carry_q. There is no Cin port.
- Flags:
  - Z = (result == 0).
  - S = result[WIDTH-1].
  - P = 1 when result[7:0] has an even number of ones.
  - Arithmetic C = carry out, or borrow for SUB/SBB/DEC.
  - Arithmetic V = signed overflow.
  - Arithmetic AF = carry out of bit 3, or borrow into bit 3.
  - INC/DEC leave C unchanged.
  - Logic ops: C = V = AF = 0.
- Shifts/rotates:
  - Count n = b[CW-1:0]. Each SHIFT cycle performs one 1-bit step.
  - C = the last bit shifted out; RCL/RCR step through {carry_q, a}.
  - V = result[WIDTH-1] ^ a[WIDTH-1].
  - AF = 0.
  - n = 0: result = a, C = carry_q, V = 0.
- FSM states:
  - IDLE: accept. Single-cycle ops → DONE. Shift/rotate with n > 0 → SHIFT. Shift/rotate with n = 0 → DONE. MUL (when built) → MUL.
  - SHIFT: decrement the step counter; → DONE when it reaches 0.
  - DONE: out_valid = 1; → IDLE on out_ready.
- in_ready = (state == IDLE). An accepted op's operands are captured and stay stable internally; input changes after acceptance have no effect.

## Timing
- Reset values: out_valid = 0, in_ready = 0 during rst, result = 0, status = 0, carry_q = 0, state = IDLE. in_ready = 1 from the first cycle after rst deasserts.
- Latency from acceptance edge to out_valid:
  - Single-cycle ops and n = 0 shifts: 1 cycle.
  - Shift by n: n+1 cycles.
  - MUL: WIDTH+1 cycles.
- result/status hold stable while out_valid && !out_ready.
- carry_q updates on the edge entering DONE.
- Throughput is one op per 2 cycles minimum. No acceptance occurs in the DONE cycle.
- rst mid-SHIFT/MUL/DONE: the operation is discarded and no out_valid is produced. All reset values apply on the next cycle.

## Configuration
- ALU_MUL_EN defined: opcode 11000 MUL performs an unsigned shift-add multiply, one partial product per cycle.
  - result = low WIDTH bits.
  - C = V = (high WIDTH bits != 0).
  - Z/S/P from result; AF = 0.
- ALU_MUL_EN undefined: 11000 is an unused opcode and the MUL state and hardware are absent.

## Structure
- alu_pkg holds:
  - opcode localparams;
  - status bit indices (ST_C, ST_Z, ST_S, ST_P, ST_V, ST_AF);
  - the FSM state enum.
- Sub-module alu_seq_core: combinational single-cycle datapath that computes the result and the six flags from a, b, op and carry_q. The top-level module holds the FSM, the shift/MUL iteration registers and the output register.

## Test plan
All scenarios use WIDTH = 16.
- ADD 0x7FFF + 0x0001 → result 0x8000, S=1, V=1, AF=1, C=0, Z=0; out_valid exactly 1 cycle after acceptance.
- SUB 0xFFFE − 0xFFFF → 0xFFFF, C=1, S=1. Follow with SBB 0x0007 − 0x0003 → 0x0003 (stored carry consumed), C=0.
- Set carry_q = 1, then RCR a=0x8F00, n=3 → 0x31E0, C=0. out_valid 4 cycles after acceptance; in_ready low throughout.
- Hold out_ready = 0 for 5 cycles after AND 0x0007 & 0x0003 → result 0x0003 and status stable, in_ready = 0, no new acceptance; one transfer when out_ready rises.
- ROL n=15 on 0xF0F0, then assert rst 5 cycles after acceptance → next cycle state IDLE, out_valid = 0, result = 0, carry_q = 0, and no result emitted.
- With ALU_MUL_EN defined: MUL 0x0100 × 0x0100 → result 0x0000, Z=1, C=V=1, latency 17 cycles. Without the macro, the same op → result 0, status unchanged, latency 1.
